// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the segmented adder/subtractor.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package pipelined_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of SEG-bit pipeline stages needed to cover WIDTH bits.
    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// One SEG-bit slice of the carry chain: a + (b ^ op) + cin, purely combinational.
// Latency: 0 cycles; the caller registers the slice outputs.
// Backpressure: none, no state.
module addsub_segment
    import pipelined_addsub_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           op,
    input  logic           cin,
    output logic [SEG-1:0] s_seg,
    output logic           cout_seg,
    output logic           c_msb
);

    logic [SEG-1:0] b_eff;
    logic [SEG:0]   sum;

    assign b_eff    = (op == OP_SUB) ? ~b_seg : b_seg;
    assign sum      = {1'b0, a_seg} + {1'b0, b_eff} + {{SEG{1'b0}}, cin};
    assign s_seg    = sum[SEG-1:0];
    assign cout_seg = sum[SEG];
    // Carry into the slice MSB, recovered from the sum bit; XOR with cout gives signed overflow.
    assign c_msb    = a_seg[SEG-1] ^ b_eff[SEG-1] ^ s_seg[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub with the carry chain cut into SEG-bit register stages.
// Latency: N = WIDTH/SEG cycles from accept to out_valid; one beat per cycle sustained.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready follows that.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEG      = 8,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int N = num_stages(WIDTH, SEG);

    logic             advance;
    logic             out_valid_d, cout_d, ovf_d, zero_d;
    logic [WIDTH-1:0] s_d;
    logic             out_valid_q, cout_q, ovf_q, zero_q;
    logic [WIDTH-1:0] s_q;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    // Bubbles are not collapsed: the pipe moves as one unit whenever the output slot frees.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < N; k++) begin : g_st
        localparam int IW = WIDTH - k*SEG;  // operand bits not yet summed at this stage

        logic [IW-1:0]        a_src, b_src;
        logic                 op_src, c_src, v_src;
        logic [SEG-1:0]       s_seg;
        logic                 c_seg;
        logic [(k+1)*SEG-1:0] r_cur;  // result segments completed so far, this one on top

        if (k == 0) begin : g_in
            assign a_src  = a;
            assign b_src  = b;
            assign op_src = op;
            assign c_src  = cin;
            assign v_src  = in_valid;
            assign r_cur  = s_seg;
        end else begin : g_in
            assign a_src  = g_st[k-1].g_reg.a_q;
            assign b_src  = g_st[k-1].g_reg.b_q;
            assign op_src = g_st[k-1].g_reg.op_q;
            assign c_src  = g_st[k-1].g_reg.c_q;
            assign v_src  = g_st[k-1].g_reg.v_q;
            assign r_cur  = {s_seg, g_st[k-1].g_reg.r_q};
        end

        if (k < N-1) begin : g_reg
            logic                 c_msb_unused;  // only the top slice's sign carry matters
            logic                 v_q, v_d, c_q, c_d, op_q, op_d;
            logic [IW-SEG-1:0]    a_q, a_d, b_q, b_d;        // skew: upper operand segments
            logic [(k+1)*SEG-1:0] r_q, r_d;                  // deskew: finished lower result

            addsub_segment #(.SEG(SEG)) u_seg (
                .a_seg    (a_src[SEG-1:0]),
                .b_seg    (b_src[SEG-1:0]),
                .op       (op_src),
                .cin      (c_src),
                .s_seg    (s_seg),
                .cout_seg (c_seg),
                .c_msb    (c_msb_unused)
            );

            assign v_d  = v_src;
            assign c_d  = c_seg;
            assign op_d = op_src;
            assign a_d  = a_src[IW-1:SEG];
            assign b_d  = b_src[IW-1:SEG];
            assign r_d  = r_cur;

            // Stage valid: cleared by reset, otherwise shifts with the pipe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_d;
                end
            end

            // Stage payload: no reset needed, qualified by v_q downstream.
            always_ff @(posedge clk) begin
                if (advance) begin
                    c_q  <= c_d;
                    op_q <= op_d;
                    a_q  <= a_d;
                    b_q  <= b_d;
                    r_q  <= r_d;
                end
            end
        end else begin : g_out
            logic             c_msb, ovf_raw;
            logic [WIDTH-1:0] sat_val;

            addsub_segment #(.SEG(SEG)) u_seg (
                .a_seg    (a_src[SEG-1:0]),
                .b_seg    (b_src[SEG-1:0]),
                .op       (op_src),
                .cin      (c_src),
                .s_seg    (s_seg),
                .cout_seg (c_seg),
                .c_msb    (c_msb)
            );

            assign ovf_raw = c_msb ^ c_seg;
            // On overflow the raw sign is the inverse of the operands' sign, so it picks the clamp.
            assign sat_val = r_cur[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                            : {1'b1, {(WIDTH-1){1'b0}}};

            assign out_valid_d = v_src;
            assign cout_d      = c_seg;
            assign ovf_d       = ovf_raw;
            assign s_d         = ((SATURATE != 0) && ovf_raw) ? sat_val : r_cur;
            assign zero_d      = (s_d == '0);
        end
    end

    assign ovf_cnt_d = (out_valid_q && out_ready && ovf_q && (ovf_cnt_q != '1))
                     ? ovf_cnt_q + CNT_W'(1) : ovf_cnt_q;

    // Output stage: the last pipeline register, frozen while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    // Overflow event counter: counts delivered overflowing beats, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: three DUT flavours (N=4 wrap, N=1 with 2-bit counter, N=4 saturating)
// share one operand stream; each accepted beat queues its expected result per DUT and
// a negedge monitor compares every delivered beat and the overflow counter.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_op = 1'b0;

    logic [2:0]  rdy, ov, co, of, zr;
    logic [31:0] s_o [3];
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    int          checks = 0;
    int          errors = 0;
    res_t        sbq [3][$];
    logic [15:0] mcnt [3];
    int          delivered [3];
    int          lat [3];
    int          d0;
    bit          rnd_done;
    res_t        e;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .SEG(8), .SATURATE(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(in_a), .b(in_b), .cin(in_cin), .op(in_op),
        .out_valid(ov[0]), .out_ready(out_ready), .s(s_o[0]), .cout(co[0]),
        .ovf(of[0]), .zero(zr[0]), .ovf_cnt(cnt0));

    pipelined_addsub #(.WIDTH(32), .SEG(32), .SATURATE(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(in_a), .b(in_b), .cin(in_cin), .op(in_op),
        .out_valid(ov[1]), .out_ready(out_ready), .s(s_o[1]), .cout(co[1]),
        .ovf(of[1]), .zero(zr[1]), .ovf_cnt(cnt1));

    pipelined_addsub #(.WIDTH(32), .SEG(8), .SATURATE(1), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(in_a), .b(in_b), .cin(in_cin), .op(in_op),
        .out_valid(ov[2]), .out_ready(out_ready), .s(s_o[2]), .cout(co[2]),
        .ovf(of[2]), .zero(zr[2]), .ovf_cnt(cnt2));

    function automatic logic [15:0] get_cnt(input int i);
        case (i)
            0:       return cnt0;
            1:       return {14'b0, cnt1};
            default: return cnt2;
        endcase
    endfunction

    function automatic logic [15:0] cnt_max(input int i);
        return (i == 1) ? 16'd3 : 16'hFFFF;
    endfunction

    // Reference: exact integer arithmetic, overflow = true value outside the signed range.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic o, input bit sat);
        res_t        r;
        logic [31:0] bb;
        logic [32:0] u;
        longint      sa, sb, tru;
        bb  = o ? ~b : b;
        u   = {1'b0, a} + {1'b0, bb} + {32'b0, c};
        sa  = longint'($signed(a));
        sb  = longint'($signed(bb));
        tru = sa + sb + (c ? 64'sd1 : 64'sd0);
        r.cout = u[32];
        r.ovf  = (tru > SMAX) || (tru < SMIN);
        if (sat && tru > SMAX)      r.s = 32'h7FFFFFFF;
        else if (sat && tru < SMIN) r.s = 32'h80000000;
        else                        r.s = u[31:0];
        r.zero = (r.s == 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h00000001;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one beat and hold it until DUT0 takes it; returns 1ns after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic o);
        int n;
        in_a = a; in_b = b; in_cin = c; in_op = o; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(rdy[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                sbq[i].delete();
                mcnt[i] = '0;
            end else begin
                if (ov[i] && out_ready) begin
                    chk($sformatf("expected_beat_present u%0d", i), 64'(sbq[i].size() > 0), 64'd1);
                    if (sbq[i].size() > 0) begin
                        e = sbq[i].pop_front();
                        chk($sformatf("result u%0d", i),
                            64'({s_o[i], co[i], of[i], zr[i]}), 64'(e));
                        chk($sformatf("ovf_cnt u%0d", i), 64'(get_cnt(i)), 64'(mcnt[i]));
                        if (e.ovf && mcnt[i] < cnt_max(i)) mcnt[i] = mcnt[i] + 16'd1;
                        delivered[i]++;
                    end
                end
                if (in_valid && rdy[i])
                    sbq[i].push_back(model(in_a, in_b, in_cin, in_op, (i == 2)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            delivered[i] = 0;
            mcnt[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_state u%0d", i),
                64'({rdy[i], ov[i], s_o[i], co[i], of[i], zr[i], get_cnt(i)}),
                64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}));

        // Latency from the accept edge to out_valid.
        @(posedge clk); #1;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (ov[i] && lat[i] == 0) lat[i] = k;
        end
        chk("latency u0", 64'(lat[0]), 64'd4);
        chk("latency u1", 64'(lat[1]), 64'd1);
        chk("latency u2", 64'(lat[2]), 64'd4);

        // Directed arithmetic corners, back to back.
        @(posedge clk); #1;
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b1, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("directed_ovf_cnt u%0d", i), 64'(get_cnt(i)), 64'd2);

        // Backpressure: out_ready low for four cycles while eight beats stream in.
        d0 = delivered[0];
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("in_ready_during_stall", 64'(rdy[0]), 64'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("backpressure_delivered u0", 64'(delivered[0] - d0), 64'd8);

        // Reset with three beats in flight: none may come out afterwards.
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        send(32'd300, 32'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_out_valid u%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("midrst_ovf_cnt u%0d", i), 64'(get_cnt(i)), 64'd0);
        end
        repeat (10) @(posedge clk);
        #1;

        // Random operands with random downstream stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++)
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drained u%0d", i), 64'(sbq[i].size()), 64'd0);
            chk($sformatf("final_ovf_cnt u%0d", i), 64'(get_cnt(i)), 64'(mcnt[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the K-means datapath (distance deltas, centroid sums). The carry chain is split into SEG-bit segments with one register stage per segment, so WIDTH can grow without a long ripple path. A valid/ready handshake sits on both sides, with global stall, and the unit provides carry/overflow/zero flags, optional saturation and a running overflow counter.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
SEG, 8, bits per pipeline segment; N = WIDTH/SEG stages (N >= 1).
SATURATE, 0, 1 = clamp signed overflow to the max/min representable value.
CNT_W, 16, width of the overflow event counter.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in to bit 0
op  in  1  0 = add (a+b+cin), 1 = sub (a+~b+cin); callers drive cin=1 for true a-b
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  result
cout  out  1  carry out of MSB (for sub: 1 = no borrow)
ovf  out  1  signed overflow of this result
zero  out  1  s == 0 (after saturation)
ovf_cnt  out  CNT_W  count of delivered results with ovf=1, saturating at all-ones

Behaviour:
- Interface is decided as: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, s=0, cout=0, ovf=0, zero=0, ovf_cnt=0. All stage valid bits are cleared.
- Accept: a beat is accepted when in_valid && in_ready.
- advance = !out_valid || out_ready; in_ready = advance. The whole pipe shifts only on advance.
- No bubble collapse: internal bubbles propagate.
- Latency: exactly N cycles from the accept edge to out_valid=1 when unstalled. N=1 gives single-cycle registered output.
- Throughput: one beat per cycle when out_ready is held high.
- Stage k (0..N-1) adds segment k of a and (b^{WIDTH{op}}) plus the carry registered by stage k-1. Stage 0 uses cin.
- Upper operand segments are carried forward in skew registers. Completed lower result segments are carried forward in deskew registers. All segments of a beat therefore emerge together, in order.
- cout = carry out of segment N-1.
- ovf = (a[MSB] == b'[MSB]) && (raw_s[MSB] != a[MSB]), where b' is the op-conditioned B.
- SATURATE=1 and ovf: s = a[MSB] ? {1,0...0} : {0,1...1}. cout and ovf still report raw values.
- SATURATE=0: s = raw sum mod 2^WIDTH.
- ovf_cnt increments on an output handshake (out_valid && out_ready) with ovf=1. It holds at 2^CNT_W-1.
- Stall: when out_valid && !out_ready, every stage and the outputs hold their values. No beat is dropped or duplicated.
- Simultaneous accept and deliver in the same cycle is legal and keeps full throughput.
- rst mid-operation: all in-flight beats are discarded. Outputs take reset values next cycle. ovf_cnt clears.
- Operand changes while in_ready=0 have no effect.

Decomposition:
- Package pipelined_addsub_pkg: op encodings (OP_ADD=0, OP_SUB=1) and a helper function for the stage count N.
- Sub-module addsub_segment: a combinational SEG-bit full-adder chain, with inputs a_seg, b_seg, op, cin and outputs s_seg, cout_seg, plus the MSB carry-in needed for overflow.
- The top level instantiates N addsub_segment and owns all pipeline, skew/deskew, handshake, saturation and counter registers.

Test Plan:
All cases use WIDTH=32, SEG=8 (latency 4) unless stated.
1. Add, op=0, a=0x000000FF, b=0x00000001, cin=0 -> 4 cycles later s=0x00000100, cout=0, ovf=0, zero=0.
2. Full carry ripple across segments, a=0xFFFFFFFF, b=0x00000001, cin=0 -> s=0x00000000, cout=1, zero=1, ovf=0.
3. Subtract, op=1, a=5, b=7, cin=1 -> s=0xFFFFFFFE, cout=0 (borrow), ovf=0. Same op with a=7, b=5 -> s=2, cout=1.
4. Overflow, a=0x7FFFFFFF, b=1, add -> s=0x80000000, ovf=1, ovf_cnt=1. With SATURATE=1 -> s=0x7FFFFFFF, ovf=1. Also a=0x80000000, b=1, sub, cin=1 with SATURATE=1 -> s=0x80000000.
5. Backpressure: 8 back-to-back beats (a=i, b=i) with out_ready low on cycles 5-8 -> in_ready low during the stall, results 0,2,4,...,14 delivered in order with no loss or duplicates.
6. Reset mid-flight: assert rst for 1 cycle with 3 beats in the pipe -> next cycle out_valid=0 and ovf_cnt=0. None of the 3 beats ever appears. Also run with SEG=32 (N=1): latency 1.
